// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (A = CPU, B = loader) arbiter in front of a single-ported wait-state memory
// Ports: clk, rst (async, active-low); per port x in {a,b}: x_req/x_we/x_adr/x_wdata in, x_gnt/x_ack/x_err out;
//        rdata shared read result; mem_adr/mem_data/mem_write/mem_read drive the memory, mem_out returns read data.
module mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int unsigned MEM_DEPTH = 1000,
  parameter int WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              b_req,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] a_adr,
  input  logic [ADDR_W-1:0] b_adr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_ack,
  output logic              b_ack,
  output logic              a_err,
  output logic              b_err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_out
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic r_sel, r_last, r_err;
  logic w_sel_b, w_we, w_oor;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_wdata;
  // r_last = 1 means B was granted last, so A wins the next conflict
  assign w_sel_b = b_req & (~a_req | ~r_last);
  assign w_we    = w_sel_b ? b_we : a_we;
  assign w_adr   = w_sel_b ? b_adr : a_adr;
  assign w_wdata = w_sel_b ? b_wdata : a_wdata;
  assign w_oor   = 32'(w_adr) >= MEM_DEPTH;
  // ack/err are registered from RESP, so they show in the cycle after RESP;
  // out-of-range requests skip ACCESS and go straight to RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_sel <= 1'b0;
      r_last <= 1'b1;
      r_err <= 1'b0;
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      a_err <= 1'b0;
      b_err <= 1'b0;
      rdata <= '0;
      mem_adr <= '0;
      mem_data <= '0;
      mem_write <= 1'b0;
      mem_read <= 1'b0;
    end else begin
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      a_ack <= r_state == RESP && !r_sel;
      b_ack <= r_state == RESP && r_sel;
      a_err <= r_state == RESP && !r_sel && r_err;
      b_err <= r_state == RESP && r_sel && r_err;
      if (r_state == IDLE && (a_req || b_req)) begin
        r_sel <= w_sel_b;
        r_last <= w_sel_b;
        a_gnt <= !w_sel_b;
        b_gnt <= w_sel_b;
        r_err <= w_oor;
        r_cnt <= 4'(WAIT);
        r_state <= w_oor ? RESP : ACCESS;
        if (!w_oor) begin
          mem_adr <= w_adr;
          mem_data <= w_wdata;
          mem_write <= w_we;
          mem_read <= !w_we;
        end
      end else if (r_state == ACCESS) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          mem_write <= 1'b0;
          mem_read <= 1'b0;
          r_state <= RESP;
          if (mem_read) rdata <= mem_out;
        end
      end else if (r_state == RESP) begin
        r_state <= IDLE;
        if (r_err) rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table plus corner-case sequences for mem_arbiter (WAIT=1 and WAIT=3 instances)
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic a_req = 0, b_req = 0, a_we = 0, b_we = 0;
  logic [9:0] a_adr = 0, b_adr = 0;
  logic [15:0] a_wdata = 0, b_wdata = 0;
  logic a_gnt1, b_gnt1, a_ack1, b_ack1, a_err1, b_err1, mem_write1, mem_read1;
  logic a_gnt3, b_gnt3, a_ack3, b_ack3, a_err3, b_err3, mem_write3, mem_read3;
  logic [15:0] rdata1, rdata3, mem_data1, mem_data3, mem_out1, mem_out3;
  logic [9:0] mem_adr1, mem_adr3;
  bit [15:0] m1 [1024];
  bit [15:0] m3 [1024];
  bit [1023:0] v1, v3;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [9:0] a);
    return {6'd0, a} * 16'd3 + 16'd1;
  endfunction

  // memory models: unwritten words read back a fixed address pattern
  always @(posedge clk) begin
    if (mem_write1) begin m1[mem_adr1] <= mem_data1; v1[mem_adr1] <= 1'b1; end
    if (mem_write3) begin m3[mem_adr3] <= mem_data3; v3[mem_adr3] <= 1'b1; end
  end
  assign mem_out1 = v1[mem_adr1] ? m1[mem_adr1] : pat(mem_adr1);
  assign mem_out3 = v3[mem_adr3] ? m3[mem_adr3] : pat(mem_adr3);

  mem_arbiter #(.WAIT(1)) u1 (
    .clk(clk), .rst(rst), .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_adr(a_adr), .b_adr(b_adr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt1), .b_gnt(b_gnt1), .a_ack(a_ack1), .b_ack(b_ack1), .a_err(a_err1), .b_err(b_err1),
    .rdata(rdata1), .mem_adr(mem_adr1), .mem_data(mem_data1), .mem_write(mem_write1),
    .mem_read(mem_read1), .mem_out(mem_out1));

  mem_arbiter #(.WAIT(3)) u3 (
    .clk(clk), .rst(rst), .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
    .a_adr(a_adr), .b_adr(b_adr), .a_wdata(a_wdata), .b_wdata(b_wdata),
    .a_gnt(a_gnt3), .b_gnt(b_gnt3), .a_ack(a_ack3), .b_ack(b_ack3), .a_err(a_err3), .b_err(b_err3),
    .rdata(rdata3), .mem_adr(mem_adr3), .mem_data(mem_data3), .mem_write(mem_write3),
    .mem_read(mem_read3), .mem_out(mem_out3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // eo = {a_gnt, b_gnt, a_ack, b_ack, a_err, b_err, mem_read, mem_write}
  typedef struct {
    logic ar, aw; logic [9:0] aa; logic [15:0] ad;
    logic br, bw; logic [9:0] ba; logic [15:0] bd;
    logic [7:0] eo; logic [9:0] ema; logic [15:0] erd;
  } vec_t;
  vec_t v [21];

  int seq [4];
  int n_g, first_g, acks_a, gcyc, nrd, ack_cyc;
  logic [15:0] ack_rd;
  logic ack_err, dbl;

  initial begin
    v[0]  = '{1, 1, 5,    16'h1234, 0, 0, 0, 0,        8'b1000_0001, 5, 16'h0};
    v[1]  = '{0, 0, 0,    0,        0, 0, 0, 0,        8'b0000_0000, 5, 16'h0};
    v[2]  = '{0, 0, 0,    0,        0, 0, 0, 0,        8'b0010_0000, 5, 16'h0};
    v[3]  = '{0, 0, 0,    0,        1, 0, 5, 0,        8'b0100_0010, 5, 16'h0};
    v[4]  = '{0, 0, 0,    0,        0, 0, 0, 0,        8'b0000_0000, 5, 16'h1234};
    v[5]  = '{0, 0, 0,    0,        0, 0, 0, 0,        8'b0001_0000, 5, 16'h1234};
    v[6]  = '{1, 0, 1000, 0,        0, 0, 0, 0,        8'b1000_0000, 5, 16'h1234};
    v[7]  = '{0, 0, 0,    0,        0, 0, 0, 0,        8'b0010_1000, 5, 16'h0};
    v[8]  = '{1, 1, 7,    16'h00AA, 1, 1, 8, 16'h00BB, 8'b0100_0001, 8, 16'h0};
    v[9]  = '{1, 1, 7,    16'h00AA, 0, 0, 0, 0,        8'b0000_0000, 8, 16'h0};
    v[10] = '{1, 1, 7,    16'h00AA, 0, 0, 0, 0,        8'b0001_0000, 8, 16'h0};
    v[11] = '{1, 1, 7,    16'h00AA, 0, 0, 0, 0,        8'b1000_0001, 7, 16'h0};
    v[12] = '{0, 0, 0,    0,        0, 0, 0, 0,        8'b0000_0000, 7, 16'h0};
    v[13] = '{0, 0, 0,    0,        0, 0, 0, 0,        8'b0010_0000, 7, 16'h0};
    v[14] = '{0, 0, 0,    0,        1, 0, 7, 0,        8'b0100_0010, 7, 16'h0};
    v[15] = '{0, 0, 0,    0,        0, 0, 0, 0,        8'b0000_0000, 7, 16'h00AA};
    v[16] = '{0, 0, 0,    0,        0, 0, 0, 0,        8'b0001_0000, 7, 16'h00AA};
    v[17] = '{0, 0, 0,    0,        1, 0, 8, 0,        8'b0100_0010, 8, 16'h00AA};
    v[18] = '{1, 0, 8,    0,        0, 0, 0, 0,        8'b0000_0000, 8, 16'h00BB};
    v[19] = '{0, 0, 0,    0,        0, 0, 0, 0,        8'b0001_0000, 8, 16'h00BB};
    v[20] = '{0, 0, 0,    0,        0, 0, 0, 0,        8'b0000_0000, 8, 16'h00BB};

    #1;
    chk("reset flags u1", {a_gnt1, b_gnt1, a_ack1, b_ack1, a_err1, b_err1, mem_read1, mem_write1}, 0);
    chk("reset flags u3", {a_gnt3, b_gnt3, a_ack3, b_ack3, a_err3, b_err3, mem_read3, mem_write3}, 0);
    chk("reset mem_adr", {mem_adr1, mem_adr3}, 0);
    chk("reset mem_data", {mem_data1, mem_data3}, 0);
    chk("reset rdata", {rdata1, rdata3}, 0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      a_req = v[i].ar; a_we = v[i].aw; a_adr = v[i].aa; a_wdata = v[i].ad;
      b_req = v[i].br; b_we = v[i].bw; b_adr = v[i].ba; b_wdata = v[i].bd;
      @(posedge clk); #1;
      chk($sformatf("row%0d flags", i), {a_gnt1, b_gnt1, a_ack1, b_ack1, a_err1, b_err1, mem_read1, mem_write1}, v[i].eo);
      chk($sformatf("row%0d mem_adr", i), mem_adr1, v[i].ema);
      chk($sformatf("row%0d rdata", i), rdata1, v[i].erd);
    end

    // async reset in the middle of an access, then both ports request at release
    @(negedge clk); a_req = 1; a_we = 0; a_adr = 3; b_req = 0;
    @(posedge clk); #1;
    chk("pre-abort a_gnt", a_gnt1, 1);
    chk("pre-abort mem_read", mem_read1, 1);
    a_req = 0;
    #2 rst = 1'b0;
    #1;
    chk("abort strobes u1", {mem_read1, mem_write1}, 0);
    chk("abort strobes u3", {mem_read3, mem_write3}, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("abort no ack", {a_ack1, b_ack1, a_ack3, b_ack3}, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    a_req = 1; a_we = 1; a_adr = 10; a_wdata = 16'h5555;
    b_req = 1; b_we = 1; b_adr = 11; b_wdata = 16'h6666;
    n_g = 0; first_g = -1; acks_a = 0; dbl = 0;
    for (int c = 0; c < 30 && n_g < 4; c++) begin
      @(posedge clk); #1;
      if (a_gnt1 && b_gnt1) dbl = 1;
      if ((a_gnt1 || b_gnt1) && first_g < 0) first_g = c;
      if (a_gnt1) begin seq[n_g] = 0; n_g++; end
      else if (b_gnt1) begin seq[n_g] = 1; n_g++; end
      if (a_ack1 && !a_err1) acks_a++;
    end
    a_req = 0; b_req = 0;
    chk("alt grant count", n_g, 4);
    chk("alt first edge grants", first_g, 0);
    chk("alt double gnt", dbl, 0);
    chk("alt acked A", acks_a > 0, 1);
    for (int k = 0; k < 4; k++) chk($sformatf("alt grant%0d port", k), k < n_g ? seq[k] : -1, k % 2);

    // WAIT=3 read at the last valid address
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    b_req = 1; b_we = 0; b_adr = 999; a_req = 0;
    gcyc = 0; nrd = 0; ack_cyc = 0; ack_rd = 0; ack_err = 1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (b_gnt3) begin b_req = 0; gcyc = c; end
      if (mem_read3) nrd++;
      if (b_ack3 && ack_cyc == 0) begin ack_cyc = c; ack_rd = rdata3; ack_err = b_err3; end
    end
    chk("w3 gnt cycle", gcyc, 1);
    chk("w3 mem_read cycles", nrd, 3);
    chk("w3 ack latency", ack_cyc - gcyc, 4);
    chk("w3 rdata", ack_rd, 16'h0BB6);
    chk("w3 b_err", ack_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter MEM_DEPTH, default 1000, number of valid words (addresses 0..MEM_DEPTH-1).
REQ-004 Parameter WAIT, default 1, range 1..15, cycles the memory strobe is held per access.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 a_req, b_req  input  1 each  access request from port A (CPU) / port B (loader).
REQ-008 a_we, b_we  input  1 each  1 = write, 0 = read.
REQ-009 a_adr, b_adr  input  ADDR_W each  word address.
REQ-010 a_wdata, b_wdata  input  DATA_W each  write data.
REQ-011 a_gnt, b_gnt  output  1 each  one-cycle pulse: request accepted and latched.
REQ-012 a_ack, b_ack  output  1 each  one-cycle pulse: access complete.
REQ-013 a_err, b_err  output  1 each  valid with ack; 1 = address out of range.
REQ-014 rdata  output  DATA_W  read result, shared, valid in the ack cycle.
REQ-015 mem_adr  output  ADDR_W  memory address.
REQ-016 mem_data  output  DATA_W  memory write data.
REQ-017 mem_write, mem_read  output  1 each  memory strobes.
REQ-018 mem_out  input  DATA_W  memory read data.

Function
REQ-019 FSM states IDLE, ACCESS, RESP; one transaction at a time.
REQ-020 IDLE with any req high at an edge: select port, latch we/adr/wdata, pulse that port's gnt for the following cycle, go to ACCESS with wait counter = WAIT.
REQ-021 Arbitration: single requester wins; both high -> port not granted last time wins; last-granted register updates on every grant.
REQ-022 Latched adr >= MEM_DEPTH: strobes never asserted, go directly to RESP with err=1, rdata=0; otherwise err=0.
REQ-023 ACCESS: mem_adr/mem_data driven from latched values, exactly one of mem_read/mem_write high (per latched we) for exactly WAIT consecutive cycles; counter decrements each cycle.
REQ-024 Counter reaching 1: next edge captures mem_out into rdata (reads only; writes leave rdata unchanged), goes to RESP.
REQ-025 RESP: ack (and err) of the granted port high for one cycle, then IDLE; no new grant in RESP.
REQ-026 Latency: sampling edge to ack rise = WAIT+1 cycles in range, 1 cycle out of range; throughput one transaction per WAIT+2 cycles.
REQ-027 Port fields may change after gnt; req must be held until gnt; req dropped before grant -> no transaction.
REQ-028 A requester holding req through ack is treated as a new request in the next IDLE.
REQ-029 All outputs registered; strobes, gnt, ack, err never high outside the states above; never two gnts or two acks in one cycle.
REQ-030 mem_adr and mem_data hold their last values outside ACCESS.

Reset
REQ-031 rst low: immediately state IDLE; gnt, ack, err, mem_read, mem_write = 0; mem_adr, mem_data, rdata = 0; last-granted = B (A wins first conflict).
REQ-032 Reset during ACCESS or RESP aborts the transaction with no ack; strobes fall without waiting for clk.
REQ-033 First edge after rst rises may grant.

Verification
REQ-034 A write adr 5 data 0x1234, WAIT=1 -> a_gnt 1 cycle, mem_write high 1 cycle with mem_adr 5, a_ack 2 cycles after sampling edge, a_err 0.
REQ-035 B read adr 5 after REQ-034 -> b_ack with rdata 0x1234, mem_read high exactly WAIT cycles.
REQ-036 A and B request same edge after reset, held -> A granted first, B granted next IDLE, then A again (alternation).
REQ-037 A read adr 1000 -> no strobe, a_ack next cycle with a_err 1, rdata 0.
REQ-038 WAIT=3, B read adr 999 -> mem_read high 3 cycles, b_ack 4 cycles after sampling edge.
REQ-039 rst low mid-ACCESS -> strobes 0 asynchronously, no ack, fresh request after release completes normally.
